// File: rtl/imem_arbiter_ctrl.sv
// Run controller and two-port access arbiter for the accumulator core's
// 128x8 single-port instruction memory.
//
// Handshake rules for both requesters:
//   req is held by the requester until gnt. gnt is combinational and means
//   the access is taken by the memory in this cycle. A granted read returns
//   rvalid for exactly one cycle, in the next cycle, to that requester only.
//   rdata follows mem_rdata while rvalid is high and holds its value
//   otherwise. Writes produce no rvalid.
module imem_arbiter_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4,
  parameter int CYC_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              start,
  input  logic              core_halt,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     starve_cnt;
  logic              host_pend;
  logic              core_pend;
  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic              core_starved;

  // State register; rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; halt has priority over start while running.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (core_halt) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    core_run  = (state == RUN);
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Arbitration: host first, unless the core has been denied STARVE_MAX
  // cycles in a row. Nothing is granted while reset is asserted.
  always_comb begin
    core_starved = (starve_cnt == SW'(STARVE_MAX));
    core_gnt  = !rst_n && (state == RUN) && core_req && (!host_req || core_starved);
    host_gnt  = !rst_n && host_req && !core_gnt;
    mem_en    = host_gnt || core_gnt;
    mem_we    = host_gnt && host_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_addr = core_addr;
    end else if (host_gnt) begin
      mem_addr = host_addr;
      if (host_we) mem_wdata = host_wdata;
    end
  end

  // Starvation counter: counts denied core cycles, only meaningful in RUN.
  always_ff @(posedge clk) begin
    if (rst_n || state != RUN || core_gnt) starve_cnt <= '0;
    else if (core_req)                     starve_cnt <= starve_cnt + SW'(1);
  end

  // Run-cycle counter: cleared on start, saturating count while in RUN.
  always_ff @(posedge clk) begin
    if (rst_n)
      cycle_count <= '0;
    else if ((state == IDLE || state == DONE) && start)
      cycle_count <= '0;
    else if (state == RUN && cycle_count != {CYC_W{1'b1}})
      cycle_count <= cycle_count + CYC_W'(1);
  end

  // Read owner tags: remember who issued last cycle's read.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      host_pend <= 1'b0;
      core_pend <= 1'b0;
    end else begin
      host_pend <= host_gnt && !host_we;
      core_pend <= core_gnt;
    end
  end

  // Hold registers so rdata keeps the last returned word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      host_rdata_q <= '0;
      core_rdata_q <= '0;
    end else begin
      if (host_rvalid) host_rdata_q <= mem_rdata;
      if (core_rvalid) core_rdata_q <= mem_rdata;
    end
  end

  // Read return: memory data passes through in the rvalid cycle.
  always_comb begin
    host_rvalid = host_pend && !rst_n;
    core_rvalid = core_pend && !rst_n;
    host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
    core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
  end

endmodule

// File: doc/imem_arbiter_ctrl.md
Name: imem_arbiter_ctrl

Overview:
- Run controller and access arbiter for the 128x8 single-port instruction memory of the accumulator core.
- Two requesters share the memory port:
  - the host loader port, for program load and readback;
  - the core fetch port, for opcode and operand fetch.
- Sequences the core through a run/halt lifecycle and counts executed cycles.
- Sits between the top-level IO decode, the core and the memory macro.

Parameters:
ADDR_W, 7, memory address width (128 entries)
DATA_W, 8, memory word width
STARVE_MAX, 4, consecutive denied core cycles before core is forced ahead of host
CYC_W, 16, width of run cycle counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; one clock, reset is synchronous and active-high (rst_n=1 resets despite name)
host_req  in  1  host access request, held until host_gnt
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access accepted this cycle (combinational)
host_rvalid  out  1  host read data valid (registered)
host_rdata  out  DATA_W  host read data
core_req  in  1  core fetch request (read only), held until core_gnt
core_addr  in  ADDR_W  fetch address
core_gnt  out  1  fetch accepted this cycle (combinational)
core_rvalid  out  1  fetch data valid (registered)
core_rdata  out  DATA_W  fetch data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en&!mem_we
start  in  1  run start pulse
core_halt  in  1  core reports HALT opcode executed
core_run  out  1  core execution enable
busy  out  1  RUN or DRAIN
done  out  1  DONE state
cycle_count  out  CYC_W  cycles spent in RUN, saturating

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; starve counter 0; rvalid owner tag cleared.
- FSM states:
  - IDLE: start -> RUN, cycle_count cleared to 0.
  - RUN: core_halt -> DRAIN; start ignored.
  - DRAIN: exactly one cycle, so any core read granted in the last RUN cycle returns its rvalid; then -> DONE.
  - DONE: start -> RUN, cycle_count cleared to 0.
- core_run = (state==RUN).
- busy = RUN|DRAIN.
- done = (state==DONE).
- cycle_count increments every cycle in RUN. It holds at all-ones on overflow and holds its value outside RUN.
- Arbitration: at most one grant per cycle; grants are combinational from the req inputs and the current state.
  - The host is eligible in every state.
  - The core is eligible only in RUN.
  - Default priority: host wins over core.
  - Starvation guard: the starve counter increments each cycle core is eligible, core_req=1 and core_gnt=0. When the counter equals STARVE_MAX, the core wins over the host. The counter clears on core_gnt or when leaving RUN.
- Memory drive on a grant:
  - mem_en=1.
  - mem_addr, mem_we and mem_wdata come from the winner; core always reads (mem_we=0).
  - With no grant, mem_en=0 and the other mem outputs are don't-care; drive them 0.
- Read return:
  - A read grant in cycle N produces rvalid=1 for exactly one cycle, in cycle N+1, to the owner of that grant only.
  - rdata = mem_rdata in that cycle; it holds its last value otherwise.
  - Write grants produce no rvalid.
- Back-to-back grants are allowed every cycle, including alternating owners.
- A core_halt in the same cycle as a core grant: the grant is honoured, the FSM goes to DRAIN, and core_rvalid fires in the DRAIN cycle.
- start and core_halt together in RUN: core_halt wins.
- Reset during any state: return to IDLE next edge and drop any pending rvalid (no rvalid after reset).
- Host writes during RUN are permitted (self-modifying code is the software's responsibility).

Test Plan:
- Reset: assert rst_n=1 for 2 cycles mid-RUN with a pending read -> all outputs 0, FSM IDLE, no rvalid in the cycle after release.
- Load/readback:
  - host writes 0x01@0, 0x05@1, 0x0A@2, each granted the same cycle;
  - then host reads addr 1 -> host_rvalid=1 one cycle later with host_rdata=0x05.
- Run fetch:
  - start pulse -> core_run=1 next cycle;
  - core_req addr 0 -> core_gnt the same cycle, core_rvalid with 0x01 one cycle later;
  - cycle_count=1 after the first RUN cycle.
- Contention with STARVE_MAX=4: host_req and core_req held continuously in RUN -> host granted 4 cycles, core granted the 5th cycle, then host again, with the counter restarting.
- Halt drain:
  - core_req granted in the same cycle as core_halt -> DRAIN next cycle with core_rvalid=1, then done=1, busy=0, core_run=0;
  - a second start -> RUN with cycle_count=0.
- Saturation with CYC_W=4: stay in RUN 20 cycles -> cycle_count stops at 15.
